// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the two-digit scan display path: FSM states,
// seven-segment codes and the segment lookup used by the shared decoder.
package display_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TENS  = 3'd1,
    GAP_T = 3'd2,
    ONES  = 3'd3,
    GAP_O = 3'd4
  } scan_state_t;

  // Segment bus order is {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return BLANK;
    endcase
  endfunction

endpackage

// File: rtl/BinaryToBinCodedDec_GL.sv
// Converts a 5-bit binary value (0..31) into tens and ones BCD digits.
module BinaryToBinCodedDec_GL (
  input  logic [4:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  // Range-compare form avoids a divider for the tiny 0..31 input range
  always_comb begin
    tens = 4'd0;
    ones = 4'(bin);
    if (bin >= 5'd30) begin
      tens = 4'd3;
      ones = 4'(bin - 5'd30);
    end else if (bin >= 5'd20) begin
      tens = 4'd2;
      ones = 4'(bin - 5'd20);
    end else if (bin >= 5'd10) begin
      tens = 4'd1;
      ones = 4'(bin - 5'd10);
    end
  end

endmodule

// File: rtl/BinaryToSevenSegUnopt_GL.sv
// Single BCD digit to seven-segment pattern; non-decimal codes blank.
module BinaryToSevenSegUnopt_GL
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = seg_code(digit);

endmodule

// File: rtl/display_scan_ctrl.sv
// Two-digit time-multiplexed scan controller: one shared seven-segment decoder,
// dwell/blank timing, and a one-deep pending buffer swapped at frame boundaries.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int DWELL    = 4,
  parameter int GAP      = 1,
  parameter int BLANK_LZ = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_val,
  output logic       in_rdy,
  input  logic [4:0] in,
  output logic [6:0] seg,
  output logic [1:0] digit_sel
);

  localparam int MAX_CNT = (DWELL > GAP) ? DWELL : GAP;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  scan_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       cur;
  logic [4:0]       pend;
  logic             pend_val;

  logic       dwell_done;
  logic       gap_done;
  logic       frame_end;
  logic       xfer;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [3:0] dec_in;
  logic [6:0] dec_seg;

  always_comb begin
    dwell_done = (cnt == DWELL_LAST);
    gap_done   = (cnt == GAP_LAST);
    frame_end  = (GAP == 0) ? (state == ONES  && dwell_done)
                            : (state == GAP_O && gap_done);
    xfer       = in_val && !pend_val;
  end

  assign in_rdy = !pend_val;

  // Counter restarts on every state change
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cur      <= '0;
      pend     <= '0;
      pend_val <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            cur   <= in;
            state <= TENS;
            cnt   <= '0;
          end
        end
        TENS: begin
          if (dwell_done) begin
            state <= (GAP == 0) ? ONES : GAP_T;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP_T: begin
          if (gap_done) begin
            state <= ONES;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ONES: begin
          if (dwell_done) begin
            state <= (GAP == 0) ? TENS : GAP_O;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP_O: begin
          if (gap_done) begin
            state <= TENS;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      // Swap and load are exclusive: a load needs pend_val low, a swap needs it high
      if (frame_end && pend_val) begin
        cur      <= pend;
        pend_val <= 1'b0;
      end else if (xfer && state != IDLE) begin
        pend     <= in;
        pend_val <= 1'b1;
      end
    end
  end

  BinaryToBinCodedDec_GL u_bcd (
    .bin  (cur),
    .tens (tens),
    .ones (ones)
  );

  assign dec_in = (state == ONES) ? ones : tens;

  BinaryToSevenSegUnopt_GL u_seg (
    .digit (dec_in),
    .seg   (dec_seg)
  );

  always_comb begin
    seg       = BLANK;
    digit_sel = 2'b00;
    case (state)
      TENS: begin
        if (!(BLANK_LZ != 0 && tens == 4'd0)) begin
          seg       = dec_seg;
          digit_sel = 2'b10;
        end
      end
      ONES: begin
        seg       = dec_seg;
        digit_sel = 2'b01;
      end
      default: begin
        seg       = BLANK;
        digit_sel = 2'b00;
      end
    endcase
  end

endmodule
